cpu_dump_ctrl: RTL

CPU_DUMP_CTRL -- requirements
Module: cpu_dump_ctrl

---
 rtl/cpu_dbg_pkg.sv | 15 +
 rtl/dump_out_reg.sv | 36 +++
 rtl/cpu_dump_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_dbg_pkg.sv
// Shared types for the CPU debug/dump logic: controller state encoding and dump word tags.
package cpu_dbg_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DUMP_RF = 3'd2,
        DUMP_DM = 3'd3,
        DONE    = 3'd4
    } dump_state_e;

    localparam logic TAG_RF = 1'b0;
    localparam logic TAG_DM = 1'b1;

endpackage

// File: rtl/dump_out_reg.sv
// One-entry output register for dump words: loads when a read returns, holds until accepted.
module dump_out_reg #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned IW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] load_data,
    input  logic            load_tag,
    input  logic [IW-1:0]   load_idx,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic            out_tag,
    output logic [IW-1:0]   out_idx
);

    // The controller only loads when the slot is empty or drains this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= 1'b0;
            out_idx   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_tag   <= load_tag;
            out_idx   <= load_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_dump_ctrl.sv
// Runs the CPU for a cycle budget or until halt, then streams the register file (and data
// memory when CPU_DUMP_DMEM_EN is defined) out through a valid/ready port.
module cpu_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned DM_WORDS = 16,
    parameter int unsigned CW       = 16
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [CW-1:0]                                          run_cycles,
    input  logic                                                   halt_req,
    output logic                                                   cpu_en,
    output logic [CW-1:0]                                          cycles_elapsed,
    output logic                                                   rf_re,
    output logic [$clog2(NREGS)-1:0]                               rf_raddr,
    input  logic [XLEN-1:0]                                        rf_rdata,
    output logic                                                   dm_re,
    output logic [$clog2(DM_WORDS)-1:0]                            dm_raddr,
    input  logic [XLEN-1:0]                                        dm_rdata,
    output logic                                                   out_valid,
    input  logic                                                   out_ready,
    output logic [XLEN-1:0]                                        out_data,
    output logic                                                   out_tag,
    output logic [$clog2((NREGS > DM_WORDS) ? NREGS : DM_WORDS)-1:0] out_idx,
    output logic                                                   done
);

    localparam int unsigned RAW = $clog2(NREGS);
    localparam int unsigned IW  = $clog2((NREGS > DM_WORDS) ? NREGS : DM_WORDS);
    localparam logic [RAW-1:0] RF_LAST = RAW'(NREGS - 1);
`ifdef CPU_DUMP_DMEM_EN
    localparam int unsigned DAW = $clog2(DM_WORDS);
    localparam logic [DAW-1:0] DM_LAST = DAW'(DM_WORDS - 1);
    localparam dump_state_e AFTER_RF = DUMP_DM;
`else
    localparam dump_state_e AFTER_RF = DONE;
`endif

    dump_state_e     state;
    dump_state_e     state_nxt;
    logic [CW-1:0]   budget;
    logic            in_flight;
    logic            issue_done;
    logic            rd_tag;
    logic [IW-1:0]   rd_idx;
    logic            dm_issue;
    logic            can_issue;
    logic            last_accept;
    logic            budget_hit;
    logic            start_ok;
    logic [XLEN-1:0] load_data;

    assign start_ok    = start && ((state == IDLE) || (state == DONE));
    assign budget_hit  = (cycles_elapsed + CW'(1)) == budget;
    assign can_issue   = !in_flight && !issue_done && (!out_valid || out_ready);
    assign last_accept = issue_done && !in_flight && out_valid && out_ready;
    assign load_data   = (rd_tag == TAG_DM) ? dm_rdata : rf_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and read strobes; strobes depend on out_ready in the same cycle.
    always_comb begin
        state_nxt = state;
        rf_re     = 1'b0;
        dm_issue  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = (run_cycles == '0) ? DUMP_RF : RUN;
                end
            end
            RUN: begin
                if (halt_req || budget_hit) begin
                    state_nxt = DUMP_RF;
                end
            end
            DUMP_RF: begin
                rf_re = can_issue;
                if (last_accept) begin
                    state_nxt = AFTER_RF;
                end
            end
            DUMP_DM: begin
                dm_issue = can_issue;
                if (last_accept) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_en         <= 1'b0;
            done           <= 1'b0;
            budget         <= '0;
            cycles_elapsed <= '0;
            in_flight      <= 1'b0;
            issue_done     <= 1'b0;
            rd_tag         <= TAG_RF;
            rd_idx         <= '0;
            rf_raddr       <= '0;
`ifdef CPU_DUMP_DMEM_EN
            dm_raddr       <= '0;
`endif
        end else begin
            cpu_en    <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
            in_flight <= rf_re || dm_issue;

            if (start_ok) begin
                budget         <= run_cycles;
                cycles_elapsed <= '0;
            end else if (state == RUN) begin
                cycles_elapsed <= cycles_elapsed + CW'(1);
            end

            if (rf_re) begin
                rd_tag <= TAG_RF;
                rd_idx <= IW'(rf_raddr);
                if (rf_raddr == RF_LAST) begin
                    issue_done <= 1'b1;
                end else begin
                    rf_raddr <= rf_raddr + RAW'(1);
                end
            end
`ifdef CPU_DUMP_DMEM_EN
            if (dm_issue) begin
                rd_tag <= TAG_DM;
                rd_idx <= IW'(dm_raddr);
                if (dm_raddr == DM_LAST) begin
                    issue_done <= 1'b1;
                end else begin
                    dm_raddr <= dm_raddr + DAW'(1);
                end
            end
`endif

            // Every phase starts with fresh address counters.
            if (state_nxt != state) begin
                issue_done <= 1'b0;
                rf_raddr   <= '0;
`ifdef CPU_DUMP_DMEM_EN
                dm_raddr   <= '0;
`endif
            end
        end
    end

`ifdef CPU_DUMP_DMEM_EN
    assign dm_re = dm_issue;
`else
    assign dm_re    = 1'b0;
    assign dm_raddr = '0;
`endif

    dump_out_reg #(
        .XLEN (XLEN),
        .IW   (IW)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (in_flight),
        .load_data (load_data),
        .load_tag  (rd_tag),
        .load_idx  (rd_idx),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_idx   (out_idx)
    );

endmodule
